// File: rtl/l2_tlb_search_ctrl.sv
// l2_tlb_search_ctrl: sweeps one L2 TLB set through check_ram, arbitrates config writes and returns hit/prot/multi_hit.
module l2_tlb_search_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PAGE_SIZE      = 4096,
  parameter int SET_WIDTH      = 5,
  parameter int OFFSET_WIDTH   = 4,
  parameter int RAM_DATA_WIDTH = 32,
  localparam int RA_W          = SET_WIDTH + OFFSET_WIDTH + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic                      in_rw,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [RA_W-1:0]           cfg_addr,
  input  logic [RAM_DATA_WIDTH-1:0] cfg_wdata,
  output logic                      ram_we,
  output logic [RA_W-1:0]           port0_addr,
  output logic [RA_W-1:0]           port1_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic                      rw_o,
  output logic                      searching,
  output logic [OFFSET_WIDTH-1:0]   offset_addr_d,
  output logic                      start_search,
  output logic                      send_outputs,
  input  logic                      hit_i,
  input  logic [RA_W-1:0]           hit_addr_i,
  input  logic                      master_i,
  input  logic                      prot_i,
  input  logic                      multi_hit_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_hit,
  output logic [RA_W-1:0]           out_hit_addr,
  output logic                      out_master,
  output logic                      out_prot,
  output logic                      out_multi_hit
);
  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, RESP} state_e;
  state_e                state_q;
  logic [SET_WIDTH-1:0]    set_q;
  logic [OFFSET_WIDTH-1:0] ofs_q;
  logic                    issue;
  logic                    hit_now;
  always_comb begin
    cfg_ready    = state_q == IDLE;
    ram_we       = cfg_ready && cfg_valid;
    in_ready     = cfg_ready && !cfg_valid;
    start_search = in_ready && in_valid;
    send_outputs = out_valid && out_ready;
    issue        = state_q == SEARCH;
    hit_now      = searching && hit_i;
    port0_addr   = ram_we ? cfg_addr : issue ? {set_q, 1'b0, ofs_q} : '0;
    port1_addr   = issue ? {set_q, 1'b1, ofs_q} : '0;
    ram_wdata    = cfg_wdata;
  end
  // A hit retires the sweep early: the read issued alongside it is dropped by clearing searching.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      set_q         <= '0;
      ofs_q         <= '0;
      addr_o        <= '0;
      rw_o          <= 1'b0;
      searching     <= 1'b0;
      offset_addr_d <= '0;
      out_valid     <= 1'b0;
      out_hit       <= 1'b0;
      out_hit_addr  <= '0;
      out_master    <= 1'b0;
      out_prot      <= 1'b0;
      out_multi_hit <= 1'b0;
    end else begin
      searching <= issue && !hit_now;
      if (issue) begin
        ofs_q         <= ofs_q + 1'b1;
        offset_addr_d <= ofs_q;
      end
      if (searching) out_multi_hit <= out_multi_hit | multi_hit_i;
      if (hit_now) begin
        out_hit      <= 1'b1;
        out_hit_addr <= hit_addr_i;
        out_master   <= master_i;
        out_prot     <= prot_i;
      end
      case (state_q)
        IDLE: if (start_search) begin
          addr_o        <= in_addr;
          rw_o          <= in_rw;
          set_q         <= in_addr[IGNORE_LSB +: SET_WIDTH];
          ofs_q         <= '0;
          out_hit       <= 1'b0;
          out_hit_addr  <= '0;
          out_master    <= 1'b0;
          out_prot      <= 1'b0;
          out_multi_hit <= 1'b0;
          state_q       <= SEARCH;
        end
        SEARCH: begin
          state_q   <= hit_now ? RESP : (&ofs_q) ? DRAIN : SEARCH;
          out_valid <= hit_now;
        end
        DRAIN: begin
          state_q   <= RESP;
          out_valid <= 1'b1;
        end
        default: if (out_ready) begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l2_tlb_search_ctrl.sv
// tb_l2_tlb_search_ctrl: table-driven and randomized checks of the set sweep against a check_ram responder model.
module tb_l2_tlb_search_ctrl;
  localparam int RA_W = 10;
  localparam int N_OFS = 16;
  logic clk_i = 0, rst_i = 1;
  logic in_valid = 0, in_ready, in_rw = 0;
  logic [31:0] in_addr = 0;
  logic cfg_valid = 0, cfg_ready;
  logic [RA_W-1:0] cfg_addr = 0;
  logic [31:0] cfg_wdata = 0, ram_wdata;
  logic ram_we;
  logic [RA_W-1:0] port0_addr, port1_addr;
  logic [31:0] addr_o;
  logic rw_o, searching, start_search, send_outputs;
  logic [3:0] offset_addr_d;
  logic hit_i, master_i, prot_i, multi_hit_i;
  logic [RA_W-1:0] hit_addr_i;
  logic out_valid, out_ready = 0, out_hit, out_master, out_prot, out_multi_hit;
  logic [RA_W-1:0] out_hit_addr;
  int tests = 0, fails = 0;
  logic hit_map [N_OFS];
  logic multi_map [N_OFS];
  logic master_map [N_OFS];
  logic prot_map [N_OFS];
  logic [RA_W-1:0] haddr_map [N_OFS];

  l2_tlb_search_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_rw(in_rw), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .ram_we(ram_we), .port0_addr(port0_addr), .port1_addr(port1_addr),
    .ram_wdata(ram_wdata), .addr_o(addr_o), .rw_o(rw_o), .searching(searching),
    .offset_addr_d(offset_addr_d), .start_search(start_search), .send_outputs(send_outputs),
    .hit_i(hit_i), .hit_addr_i(hit_addr_i), .master_i(master_i), .prot_i(prot_i),
    .multi_hit_i(multi_hit_i), .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_hit_addr(out_hit_addr), .out_master(out_master), .out_prot(out_prot),
    .out_multi_hit(out_multi_hit)
  );

  always #5 clk_i = ~clk_i;

  // check_ram stand-in: the entry contents of the current set are the maps, indexed by the offset on the RAM outputs
  assign hit_i       = searching && hit_map[offset_addr_d];
  assign multi_hit_i = searching && multi_map[offset_addr_d];
  assign hit_addr_i  = haddr_map[offset_addr_d];
  assign master_i    = master_map[offset_addr_d];
  assign prot_i      = prot_map[offset_addr_d];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_maps();
    for (int i = 0; i < N_OFS; i++) begin
      hit_map[i] = 0;
      multi_map[i] = 0;
      master_map[i] = 1'($urandom);
      prot_map[i] = 1'($urandom);
      haddr_map[i] = RA_W'($urandom);
    end
  endtask

  // Issue one request and check the whole transaction against the expected result
  task automatic do_req(input logic [31:0] addr, input logic rw, input int exp_n, input logic exp_hit,
                        input logic [RA_W-1:0] exp_haddr, input logic exp_master, input logic exp_prot,
                        input logic exp_multi, input int exp_reads);
    int n;
    int q[$];
    step();
    in_addr = addr;
    in_rw = rw;
    in_valid = 1;
    #1;
    chk("in_ready_idle", in_ready, 1);
    chk("start_search", start_search, 1);
    @(posedge clk_i);
    #1;
    in_valid = 0;
    #1;
    chk("start_search_pulse", start_search, 0);
    chk("addr_o", addr_o, addr);
    chk("rw_o", rw_o, rw);
    chk("port0_first", port0_addr, {addr[16:12], 1'b0, 4'h0});
    chk("port1_first", port1_addr, {addr[16:12], 1'b1, 4'h0});
    chk("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk_i);
      #2;
      n++;
      if (searching) q.push_back(int'(offset_addr_d));
    end
    chk("latency", n, exp_n);
    chk("reads", q.size(), exp_reads);
    foreach (q[i]) if (q[i] != i) chk("read_order", q[i], i);
    chk("out_hit", out_hit, exp_hit);
    chk("out_hit_addr", out_hit_addr, exp_haddr);
    chk("out_master", out_master, exp_master);
    chk("out_prot", out_prot, exp_prot);
    chk("out_multi_hit", out_multi_hit, exp_multi);
    step();
    #1;
    chk("out_valid_hold", out_valid, 1);
    chk("out_hit_hold", out_hit, exp_hit);
    chk("no_search_in_resp", searching, 0);
    out_ready = 1;
    #1;
    chk("send_outputs", send_outputs, 1);
    @(posedge clk_i);
    #1;
    out_ready = 0;
    #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  // Reference model: first hitting offset wins; multi_hit ORs every entry read up to and including it
  task automatic run_model(input logic [31:0] addr);
    int first = -1;
    int lim;
    logic m = 0;
    for (int i = 0; i < N_OFS; i++) if (first < 0 && hit_map[i]) first = i;
    lim = (first < 0) ? N_OFS - 1 : first;
    for (int i = 0; i <= lim; i++) m |= multi_map[i];
    if (first < 0) do_req(addr, 1'($urandom), N_OFS + 1, 0, 0, 0, 0, m, N_OFS);
    else do_req(addr, 1'($urandom), first + 2, 1, haddr_map[first], master_map[first], prot_map[first], m, first + 1);
  endtask

  typedef struct {
    int hit_ofs;
    int multi_ofs;
    int exp_n;
    logic exp_hit;
    logic exp_multi;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int found;
    vecs[0] = '{0, -1, 2, 1'b1, 1'b0, 32'h0000_3000};
    vecs[1] = '{7, 7, 9, 1'b1, 1'b1, 32'h0001_F123};
    vecs[2] = '{-1, -1, 17, 1'b0, 1'b0, 32'hABCD_E000};
    vecs[3] = '{15, 2, 17, 1'b1, 1'b1, 32'h1234_5678};
    vecs[4] = '{3, 9, 5, 1'b1, 1'b0, 32'h0000_A000};
    clear_maps();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_searching", searching, 0);
    chk("rst_port0", port0_addr, 0);
    chk("rst_port1", port1_addr, 0);
    chk("rst_addr_o", addr_o, 0);
    chk("rst_out_hit", out_hit, 0);
    step();
    step();
    rst_i = 0;
    step();
    cfg_valid = 1;
    cfg_addr = 10'h025;
    cfg_wdata = 32'hDEAD_BEEF;
    #1;
    chk("cfg_ram_we", ram_we, 1);
    chk("cfg_ready", cfg_ready, 1);
    chk("cfg_port0", port0_addr, 10'h025);
    chk("cfg_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("cfg_blocks_in", in_ready, 0);
    step();
    cfg_valid = 0;
    #1;
    chk("cfg_we_pulse", ram_we, 0);
    for (int v = 0; v < 5; v++) begin
      clear_maps();
      if (vecs[v].hit_ofs >= 0) hit_map[vecs[v].hit_ofs] = 1;
      if (vecs[v].multi_ofs >= 0) multi_map[vecs[v].multi_ofs] = 1;
      do_req(vecs[v].addr, 1'(v), vecs[v].exp_n, vecs[v].exp_hit,
             vecs[v].exp_hit ? haddr_map[vecs[v].hit_ofs] : '0,
             vecs[v].exp_hit ? master_map[vecs[v].hit_ofs] : 1'b0,
             vecs[v].exp_hit ? prot_map[vecs[v].hit_ofs] : 1'b0,
             vecs[v].exp_multi, vecs[v].exp_hit ? vecs[v].hit_ofs + 1 : N_OFS);
    end
    // config write and request in the same idle cycle: write wins, request follows
    clear_maps();
    step();
    cfg_valid = 1;
    cfg_addr = 10'h1F0;
    in_valid = 1;
    in_addr = 32'h0000_7000;
    #1;
    chk("both_ram_we", ram_we, 1);
    chk("both_in_ready", in_ready, 0);
    chk("both_start", start_search, 0);
    step();
    cfg_valid = 0;
    in_valid = 0;
    #1;
    chk("both_ram_we_off", ram_we, 0);
    do_req(32'h0000_7000, 0, N_OFS + 1, 0, 0, 0, 0, 0, N_OFS);
    // asynchronous reset in the middle of a sweep
    step();
    in_addr = 32'h0000_5000;
    in_valid = 1;
    step();
    in_valid = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (searching && offset_addr_d == 4'd5) found = 1;
    end
    chk("reach_ofs5", found, 1);
    #2;
    rst_i = 1;
    #1;
    chk("arst_searching", searching, 0);
    chk("arst_offset", offset_addr_d, 0);
    chk("arst_addr_o", addr_o, 0);
    chk("arst_port0", port0_addr, 0);
    chk("arst_port1", port1_addr, 0);
    chk("arst_out_valid", out_valid, 0);
    step();
    rst_i = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    do_req(32'h0000_5000, 1, N_OFS + 1, 0, 0, 0, 0, 0, N_OFS);
    for (int r = 0; r < 20; r++) begin
      clear_maps();
      for (int i = 0; i < N_OFS; i++) begin
        hit_map[i] = ($urandom_range(0, 11) == 0);
        multi_map[i] = ($urandom_range(0, 5) == 0);
      end
      run_model($urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
